// File: rtl/usb_cmd_parser.sv
// usb_cmd_parser: pops bytes from a non-showahead USB FIFO, frames
// SYNC/OPCODE/LEN/payload/CSUM packets, streams the payload with
// valid/ready handshaking and keeps a saturating count of bad packets.
// Optional build macro USB_PARSER_TIMEOUT_EN abandons a packet after
// TIMEOUT_CYC idle cycles; without it a stalled packet waits forever.
module usb_cmd_parser #(
    parameter int unsigned MAX_LEN     = 64,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic        clk50,
    input  logic        aclr,
    input  logic [7:0]  fifo_q,
    input  logic        fifo_rdempty,
    output logic        fifo_rdreq,
    output logic        cmd_start,
    output logic [7:0]  cmd_opcode,
    output logic [7:0]  cmd_len,
    output logic [7:0]  pay_data,
    output logic        pay_valid,
    input  logic        pay_ready,
    output logic        pkt_done,
    output logic        pkt_err,
    output logic [15:0] err_cnt
);

    typedef enum logic [2:0] {S_HUNT, S_OPC, S_LEN, S_PAY, S_CSUM} state_t;

    state_t      r_state, w_state_n;
    logic        r_rd_pend;
    logic [7:0]  r_opc, w_opc_n;
    logic [7:0]  r_csum, w_csum_n;
    logic [7:0]  r_remain, w_remain_n;
    logic        r_cmd_start, w_cmd_start_n;
    logic [7:0]  r_cmd_opcode, w_cmd_opcode_n;
    logic [7:0]  r_cmd_len, w_cmd_len_n;
    logic [7:0]  r_pay_data, w_pay_data_n;
    logic        r_pay_valid, w_pay_valid_n;
    logic        r_pkt_done, w_pkt_done_n;
    logic        r_pkt_err, w_pkt_err_n;
    logic [15:0] r_err_cnt, w_err_cnt_n;
    logic        w_cap, w_xfer, w_bad, w_rdreq;
`ifdef USB_PARSER_TIMEOUT_EN
    logic [31:0] r_idle, w_idle_n;
`else
    logic        w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT_CYC == 0);
`endif

    // A pop is issued only with one byte in flight at most and never while
    // the payload stage is stalled, so a captured byte always has a home.
    assign w_rdreq = !aclr && !fifo_rdempty && !r_rd_pend && !(r_pay_valid && !pay_ready);
    assign w_cap   = r_rd_pend;
    assign w_xfer  = r_pay_valid && pay_ready;

    // Next-state and next-output computation for the packet FSM.
    always_comb begin
        w_state_n      = r_state;
        w_opc_n        = r_opc;
        w_csum_n       = r_csum;
        w_remain_n     = r_remain;
        w_cmd_start_n  = 1'b0;
        w_cmd_opcode_n = r_cmd_opcode;
        w_cmd_len_n    = r_cmd_len;
        w_pay_data_n   = r_pay_data;
        w_pay_valid_n  = r_pay_valid;
        w_pkt_done_n   = 1'b0;
        w_pkt_err_n    = r_pkt_err;
        w_bad          = 1'b0;

        if (w_xfer) begin
            w_pay_valid_n = 1'b0;
            w_remain_n    = r_remain - 8'd1;
            if (r_remain == 8'd1) w_state_n = S_CSUM;
        end

        if (w_cap) begin
            unique case (r_state)
                S_HUNT: if (fifo_q == SYNC_BYTE) w_state_n = S_OPC;
                S_OPC: begin
                    w_opc_n   = fifo_q;
                    w_csum_n  = fifo_q;
                    w_state_n = S_LEN;
                end
                S_LEN: begin
                    if (fifo_q == 8'd0 || 32'(fifo_q) > MAX_LEN) begin
                        w_pkt_done_n = 1'b1;
                        w_pkt_err_n  = 1'b1;
                        w_bad        = 1'b1;
                        w_state_n    = S_HUNT;
                    end else begin
                        w_cmd_opcode_n = r_opc;
                        w_cmd_len_n    = fifo_q;
                        w_cmd_start_n  = 1'b1;
                        w_remain_n     = fifo_q;
                        w_csum_n       = r_csum ^ fifo_q;
                        w_state_n      = S_PAY;
                    end
                end
                S_PAY: begin
                    w_pay_data_n  = fifo_q;
                    w_pay_valid_n = 1'b1;
                    w_csum_n      = r_csum ^ fifo_q;
                end
                S_CSUM: begin
                    w_pkt_done_n = 1'b1;
                    w_pkt_err_n  = (fifo_q != r_csum);
                    w_bad        = (fifo_q != r_csum);
                    w_state_n    = S_HUNT;
                end
                default: w_state_n = S_HUNT;
            endcase
        end

`ifdef USB_PARSER_TIMEOUT_EN
        w_idle_n = '0;
        if (r_state != S_HUNT && !w_cap && !w_xfer) begin
            w_idle_n = r_idle + 32'd1;
            if (w_idle_n >= TIMEOUT_CYC) begin
                w_idle_n      = '0;
                w_pkt_done_n  = 1'b1;
                w_pkt_err_n   = 1'b1;
                w_bad         = 1'b1;
                w_pay_valid_n = 1'b0;
                w_state_n     = S_HUNT;
            end
        end
`endif

        w_err_cnt_n = r_err_cnt;
        if (w_bad && r_err_cnt != 16'hFFFF) w_err_cnt_n = r_err_cnt + 16'd1;
    end

    // State and output registers; reset drops any packet in progress.
    always_ff @(posedge clk50 or posedge aclr) begin
        if (aclr) begin
            r_state      <= S_HUNT;
            r_rd_pend    <= 1'b0;
            r_opc        <= '0;
            r_csum       <= '0;
            r_remain     <= '0;
            r_cmd_start  <= 1'b0;
            r_cmd_opcode <= '0;
            r_cmd_len    <= '0;
            r_pay_data   <= '0;
            r_pay_valid  <= 1'b0;
            r_pkt_done   <= 1'b0;
            r_pkt_err    <= 1'b0;
            r_err_cnt    <= '0;
`ifdef USB_PARSER_TIMEOUT_EN
            r_idle       <= '0;
`endif
        end else begin
            r_state      <= w_state_n;
            r_rd_pend    <= w_rdreq;
            r_opc        <= w_opc_n;
            r_csum       <= w_csum_n;
            r_remain     <= w_remain_n;
            r_cmd_start  <= w_cmd_start_n;
            r_cmd_opcode <= w_cmd_opcode_n;
            r_cmd_len    <= w_cmd_len_n;
            r_pay_data   <= w_pay_data_n;
            r_pay_valid  <= w_pay_valid_n;
            r_pkt_done   <= w_pkt_done_n;
            r_pkt_err    <= w_pkt_err_n;
            r_err_cnt    <= w_err_cnt_n;
`ifdef USB_PARSER_TIMEOUT_EN
            r_idle       <= w_idle_n;
`endif
        end
    end

    assign fifo_rdreq = w_rdreq;
    assign cmd_start  = r_cmd_start;
    assign cmd_opcode = r_cmd_opcode;
    assign cmd_len    = r_cmd_len;
    assign pay_data   = r_pay_data;
    assign pay_valid  = r_pay_valid;
    assign pkt_done   = r_pkt_done;
    assign pkt_err    = r_pkt_err;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_usb_cmd_parser.sv
// Testbench for usb_cmd_parser: table of packets plus hand sequences,
// with a FIFO model and an event scoreboard.
module tb_usb_cmd_parser;

    localparam int K_START = 0;
    localparam int K_PAY   = 1;
    localparam int K_DONE  = 2;

    logic        clk50, aclr;
    logic [7:0]  fifo_q;
    logic        fifo_rdempty, fifo_rdreq;
    logic        cmd_start;
    logic [7:0]  cmd_opcode, cmd_len, pay_data;
    logic        pay_valid, pay_ready, pkt_done, pkt_err;
    logic [15:0] err_cnt;

    usb_cmd_parser #(.MAX_LEN(64), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(100)) dut (
        .clk50(clk50), .aclr(aclr), .fifo_q(fifo_q), .fifo_rdempty(fifo_rdempty),
        .fifo_rdreq(fifo_rdreq), .cmd_start(cmd_start), .cmd_opcode(cmd_opcode),
        .cmd_len(cmd_len), .pay_data(pay_data), .pay_valid(pay_valid),
        .pay_ready(pay_ready), .pkt_done(pkt_done), .pkt_err(pkt_err), .err_cnt(err_cnt)
    );

    initial clk50 = 1'b0;
    always #5 clk50 = ~clk50;

    typedef struct {
        int          kind;
        logic [7:0]  a;
        logic [15:0] b;
    } ev_t;

    typedef struct {
        int         n;
        logic [7:0] b [0:71];
        logic       exp_start;
        logic [7:0] opc;
        logic [7:0] len;
        int         npay;
        logic [7:0] pay [0:63];
        logic       exp_err;
        logic       bp;
    } vec_t;

    localparam int NV = 8;
    vec_t        vt [0:NV-1];
    ev_t         sb [$];
    logic [7:0]  fq [$];
    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_cnt = '0;
    logic        bp = 1'b0;
    int          stall = 0;
    logic [7:0]  held = '0;

    function automatic vec_t mk(input logic [7:0] bytes [$], input logic st,
                                input logic [7:0] opc, input logic [7:0] len,
                                input logic [7:0] pay [$], input logic err, input logic bpv);
        vec_t v;
        v.n = bytes.size();
        for (int i = 0; i < 72; i++) v.b[i] = (i < v.n) ? bytes[i] : 8'h00;
        v.exp_start = st;
        v.opc = opc;
        v.len = len;
        v.npay = pay.size();
        for (int i = 0; i < 64; i++) v.pay[i] = (i < v.npay) ? pay[i] : 8'h00;
        v.exp_err = err;
        v.bp = bpv;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic sb_push(input int kind, input logic [7:0] a, input logic [15:0] b);
        ev_t e;
        e.kind = kind; e.a = a; e.b = b;
        sb.push_back(e);
    endtask

    task automatic sb_check(input string name, input int kind, input logic [7:0] a, input logic [15:0] b);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s unexpected event: got kind=%0d a=%h b=%h exp=none", name, kind, a, b);
        end else begin
            e = sb.pop_front();
            if (e.kind != kind || e.a !== a || e.b !== b) begin
                failures++;
                $display("FAIL %s got kind=%0d a=%h b=%h exp kind=%0d a=%h b=%h",
                         name, kind, a, b, e.kind, e.a, e.b);
            end
        end
    endtask

    // One clock: observe at negedge, drive pay_ready, then model the FIFO pop.
    task automatic tick();
        logic pop;
        @(negedge clk50);
        if (cmd_start) sb_check("cmd_start", K_START, cmd_opcode, {8'h00, cmd_len});
        if (pay_valid && bp && stall < 20) begin
            if (stall == 0) held = pay_data;
            else begin
                chk("stall_data", {24'h0, pay_data}, {24'h0, held});
                chk("stall_rdreq", {31'h0, fifo_rdreq}, 32'h0);
            end
            stall++;
            pay_ready = 1'b0;
        end else begin
            pay_ready = 1'b1;
            if (pay_valid) begin
                sb_check("payload", K_PAY, pay_data, 16'h0);
                stall = 0;
            end
        end
        if (pkt_done) sb_check("pkt_done", K_DONE, {7'h0, pkt_err}, err_cnt);
        #4;
        pop = fifo_rdreq;
        if (fifo_rdreq && fifo_rdempty) begin
            checks++;
            failures++;
            $display("FAIL rdreq_while_empty got=1 exp=0");
        end
        @(posedge clk50);
        #1;
        if (pop && fq.size() != 0) fifo_q = fq.pop_front();
        fifo_rdempty = (fq.size() == 0);
    endtask

    task automatic run_until_done(input int limit, output int n);
        n = 0;
        while ((sb.size() != 0 || fq.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        chk("drain_timeout", sb.size(), 0);
        sb.delete();
        repeat (4) tick();
    endtask

    task automatic apply_vec(input int i);
        int n;
        bp = vt[i].bp;
        stall = 0;
        for (int k = 0; k < vt[i].n; k++) fq.push_back(vt[i].b[k]);
        fifo_rdempty = (fq.size() == 0);
        if (vt[i].exp_start) sb_push(K_START, vt[i].opc, {8'h00, vt[i].len});
        for (int k = 0; k < vt[i].npay; k++) sb_push(K_PAY, vt[i].pay[k], 16'h0);
        if (vt[i].exp_err && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        sb_push(K_DONE, {7'h0, vt[i].exp_err}, exp_cnt);
        run_until_done(3000, n);
        bp = 1'b0;
    endtask

    initial begin
        logic [7:0] lb [$];
        logic [7:0] lp [$];
        logic [7:0] cs;
        int n;

        vt[0] = mk('{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h30}, 1'b1, 8'h01, 8'h02, '{8'h11, 8'h22}, 1'b0, 1'b0);
        vt[1] = mk('{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h31}, 1'b1, 8'h01, 8'h02, '{8'h11, 8'h22}, 1'b1, 1'b0);
        vt[2] = mk('{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h07, 8'h01, 8'h44, 8'h42}, 1'b1, 8'h07, 8'h01, '{8'h44}, 1'b0, 1'b0);
        vt[3] = mk('{8'hA5, 8'h07, 8'h41}, 1'b0, 8'h00, 8'h00, '{}, 1'b1, 1'b0);
        vt[4] = mk('{8'hA5, 8'h07, 8'h00}, 1'b0, 8'h00, 8'h00, '{}, 1'b1, 1'b0);
        vt[5] = mk('{8'hA5, 8'h01, 8'h02, 8'h11, 8'h22, 8'h30}, 1'b1, 8'h01, 8'h02, '{8'h11, 8'h22}, 1'b0, 1'b1);
        vt[6] = mk('{8'hA5, 8'hA5, 8'h01, 8'hA5, 8'h01}, 1'b1, 8'hA5, 8'h01, '{8'hA5}, 1'b0, 1'b0);
        lb = '{8'hA5, 8'h3C, 8'h40};
        cs = 8'h3C ^ 8'h40;
        for (int i = 0; i < 64; i++) begin
            lp.push_back(8'(i * 5 + 3));
            lb.push_back(8'(i * 5 + 3));
            cs = cs ^ 8'(i * 5 + 3);
        end
        lb.push_back(cs);
        vt[7] = mk(lb, 1'b1, 8'h3C, 8'h40, lp, 1'b0, 1'b0);

        aclr = 1'b1;
        fifo_q = 8'h00;
        pay_ready = 1'b1;
        fq.push_back(8'h3C);
        fifo_rdempty = 1'b0;
        repeat (3) tick();
        chk("reset_rdreq", {31'h0, fifo_rdreq}, 32'h0);
        chk("reset_outputs", {cmd_start, cmd_opcode, cmd_len, pay_data, pay_valid, pkt_done, pkt_err},
            32'h0);
        chk("reset_err_cnt", {16'h0, err_cnt}, 32'h0);
        aclr = 1'b0;
        repeat (4) tick();
        chk("garbage_consumed", fq.size(), 0);

        for (int i = 0; i < NV; i++) apply_vec(i);
        chk("err_cnt_total", {16'h0, err_cnt}, 32'd3);
        chk("fifo_empty_flag", {31'h0, fifo_rdempty}, 32'h1);

        // Reset in the middle of a packet: no pkt_done, counter cleared.
        fq.push_back(8'hA5);
        fq.push_back(8'h01);
        fifo_rdempty = 1'b0;
        n = 0;
        while (fq.size() != 0 && n < 20) begin tick(); n++; end
        repeat (3) tick();
        aclr = 1'b1;
        #1;
        chk("midreset_outputs", {cmd_start, cmd_opcode, cmd_len, pay_data, pay_valid, pkt_done, pkt_err},
            32'h0);
        chk("midreset_err_cnt", {16'h0, err_cnt}, 32'h0);
        tick();
        aclr = 1'b0;
        exp_cnt = '0;
        apply_vec(0);
        chk("post_reset_err_cnt", {16'h0, err_cnt}, 32'h0);

`ifdef USB_PARSER_TIMEOUT_EN
        fq.push_back(8'hA5);
        fq.push_back(8'h01);
        fifo_rdempty = 1'b0;
        exp_cnt = exp_cnt + 16'd1;
        sb_push(K_DONE, 8'h01, exp_cnt);
        run_until_done(400, n);
        chk("timeout_not_early", {31'h0, (n >= 100)}, 32'h1);
        chk("timeout_err_cnt", {16'h0, err_cnt}, 32'h1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
